// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: reads 64-byte lines over the cache bus
// and issues them word by word to decode, with redirect and halt-on-zero handling.
module fetch_stage #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] FETCH_TAG = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] entry,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      insn_valid,
  input  logic                      insn_ready,
  output logic [31:0]               insn,
  output logic [BUS_DATA_WIDTH-1:0] insn_pc,
  input  logic                      redirect,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      halted
);

  typedef enum logic [2:0] {IDLE, REQ, RECV, DRAIN, HALT} state_t;

  state_t                      state;
  logic [BUS_DATA_WIDTH-1:0]   pc;
  logic [BUS_DATA_WIDTH-1:0]   pend_pc;
  logic                        pend;
  logic [2:0]                  cnt;
  logic [8*BUS_DATA_WIDTH-1:0] line;
  logic [31:0]                 word;
  logic [BUS_DATA_WIDTH-1:0]   redir_pc;
  logic                        unused_bits;

  assign word        = line[{pc[5:2], 5'b0} +: 32];
  assign redir_pc    = {redirect_pc[BUS_DATA_WIDTH-1:2], 2'b0};
  assign unused_bits = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

  // Outputs decode the registered state; reset forces everything quiet at once.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    insn_valid  = 1'b0;
    insn        = '0;
    insn_pc     = '0;
    halted      = 1'b0;
    if (!reset) begin
      case (state)
        REQ: begin
          bus_reqcyc = 1'b1;
          bus_req    = {pc[BUS_DATA_WIDTH-1:6], 6'b0};
          bus_reqtag = FETCH_TAG;
        end
        RECV:  bus_respack = bus_respcyc;
        DRAIN: begin
          insn       = word;
          insn_pc    = pc;
          insn_valid = (word != 32'h0);
        end
        HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= {entry[BUS_DATA_WIDTH-1:2], 2'b0};
      pend_pc <= '0;
      pend    <= 1'b0;
      cnt     <= 3'd0;
      line    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect) pc <= redir_pc;
        end
        REQ: begin
          if (redirect) begin
            pend    <= 1'b1;
            pend_pc <= redir_pc;
          end
          if (bus_reqack) begin
            state <= RECV;
            cnt   <= 3'd0;
          end
        end
        RECV: begin
          if (redirect) begin
            pend    <= 1'b1;
            pend_pc <= redir_pc;
          end
          if (bus_respcyc) begin
            line[{cnt, 6'b0} +: BUS_DATA_WIDTH] <= bus_resp;
            cnt <= cnt + 3'd1;
            // A redirect seen during the read discards the line once all beats are in.
            if (cnt == 3'd7) begin
              if (pend || redirect) begin
                state <= REQ;
                pend  <= 1'b0;
                pc    <= redirect ? redir_pc : pend_pc;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc    <= redir_pc;
            state <= REQ;
          end else if (word == 32'h0) begin
            state <= HALT;
          end else if (insn_ready) begin
            pc <= pc + BUS_DATA_WIDTH'(4);
            if (pc[5:2] == 4'hF) state <= REQ;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage: bus responder serving
// a synthetic memory and a program-order model of the expected instruction stream.
module tb_fetch_stage;

  localparam logic [12:0] TAG = 13'h1A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = '0;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  logic        insn_valid, insn_ready, redirect, halted;
  logic [31:0] insn;
  logic [63:0] insn_pc, redirect_pc;

  int          checks = 0, errors = 0;
  int          accepts = 0, acks = 0, beat_idx = -1;
  int          ack_delay = 0, gap_len = 0, ready_mode = 0;
  bit          gap_rand = 1'b0, zero_en = 1'b0, seen_valid = 1'b0;
  logic [63:0] exp_pc = '0, zero_addr = '0;
  logic [14:0] seed = '0;

  fetch_stage #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .FETCH_TAG(TAG)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synthetic memory: every word nonzero except an optional planted zero.
  function automatic logic [31:0] mem(input logic [63:0] a);
    if (zero_en && a[63:2] == zero_addr[63:2]) return 32'h0;
    return {1'b1, seed, a[17:2]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       insn_ready = 1'b1;
      1:       insn_ready = ~insn_ready;
      default: insn_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Cache responder: acts at negedge+1, abandons everything on reset.
  initial begin
    int n, k;
    logic [63:0] ln;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    forever begin
      @(negedge clk); #1;
      if (!reset && bus_reqcyc) begin
        n = 0;
        while (n < ack_delay && !reset) begin @(negedge clk); #1; n++; end
        if (!reset) begin
          check("bus_req", bus_req, {exp_pc[63:6], 6'b0});
          check("bus_reqtag", 64'(bus_reqtag), 64'(TAG));
          ln = bus_req; bus_reqack = 1'b1; acks++;
          @(negedge clk); #1; bus_reqack = 1'b0;
          k = 0;
          while (k < 8 && !reset) begin
            n = gap_rand ? int'($urandom_range(0, gap_len)) : gap_len;
            while (n > 0 && !reset) begin @(negedge clk); #1; n--; end
            if (!reset) begin
              beat_idx = k; bus_respcyc = 1'b1;
              bus_resptag = 13'($urandom);
              bus_resp = {mem(ln + 64'(8*k + 4)), mem(ln + 64'(8*k))};
              #1; if (!reset) check("bus_respack", 64'(bus_respack), 64'd1);
              @(negedge clk); #1; bus_respcyc = 1'b0; k++;
            end
          end
          bus_respcyc = 1'b0; beat_idx = -1;
        end
      end
    end
  end

  // Decode-side model: every accepted instruction must be the next one in program order.
  initial forever begin
    @(negedge clk); #2;
    if (!reset) begin
      check("exclusive", 64'(bus_reqcyc & insn_valid), 64'd0);
      if (insn_valid) seen_valid = 1'b1;
      if (insn_valid && insn_ready && !redirect) begin
        check("insn_pc", insn_pc, exp_pc);
        check("insn", 64'(insn), 64'(mem(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        accepts++;
      end
    end
  end

  task automatic do_reset(input logic [63:0] e);
    @(negedge clk);
    reset = 1'b1; entry = e; redirect = 1'b0; insn_ready = 1'b0;
    #2 check("respack_in_reset", 64'(bus_respack), 64'd0);
    @(negedge clk); #2;
    check("reset_outputs", 64'(|{bus_reqcyc, bus_req, bus_reqtag, bus_respack,
                                 insn_valid, insn, insn_pc, halted}), 64'd0);
    reset = 1'b0; exp_pc = {e[63:2], 2'b0}; accepts = 0; acks = 0;
    #1 check("reqcyc_cycle1", 64'(bus_reqcyc), 64'd0);
    @(negedge clk); #2 check("reqcyc_cycle2", 64'(bus_reqcyc), 64'd1);
  endtask

  task automatic wait_accepts(input int n, input int budget, input string tag);
    int t = 0;
    while (accepts < n && t < budget) begin @(negedge clk); drive_ready(); #3; t++; end
    check(tag, 64'(accepts >= n), 64'd1);
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int t = 0;
    while (acks < n && t < budget) begin @(negedge clk); drive_ready(); #3; t++; end
    check(tag, 64'(acks >= n), 64'd1);
  endtask

  task automatic wait_beat(input int k, input int budget, input string tag);
    int t = 0;
    while (beat_idx != k && t < budget) begin @(negedge clk); drive_ready(); #3; t++; end
    check(tag, 64'(beat_idx == k), 64'd1);
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] ents [2];
    insn_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    seed = 15'($urandom);

    // Full line at 0x1000, ack after 3 cycles, then the next line is requested.
    ack_delay = 3; gap_len = 0; gap_rand = 1'b0; ready_mode = 0;
    do_reset(64'h1000);
    wait_accepts(16, 400, "t1_accepts");
    wait_acks(2, 100, "t1_next_line");

    // Mid-line entry and top-of-memory wrap: two words, then the next line.
    ents[0] = 64'h2038; ents[1] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int i = 0; i < 2; i++) begin
      ack_delay = int'($urandom_range(0, 2));
      do_reset(ents[i]);
      wait_accepts(2, 200, "t2_accepts");
      @(negedge clk); #1 check("t2_req_after_2", 64'(bus_reqcyc), 64'd1);
      wait_acks(2, 100, "t2_next_line");
    end

    // Gapped beats with toggling ready across several lines.
    gap_len = 2; ready_mode = 1; ack_delay = int'($urandom_range(0, 3));
    do_reset({$urandom, $urandom});
    wait_accepts(40, 3000, "t3_accepts");

    // Redirect during beat 3 of a read.
    gap_len = 0; ready_mode = 0; ack_delay = 1;
    do_reset(64'h5000);
    wait_beat(3, 100, "t4_beat3");
    redirect = 1'b1; redirect_pc = 64'h3006; exp_pc = 64'h3004; seen_valid = 1'b0;
    @(negedge clk); redirect = 1'b0;
    wait_acks(2, 100, "t4_refetch");
    check("t4_no_valid", 64'(seen_valid), 64'd0);
    wait_accepts(1, 100, "t4_first_insn");

    // Zero word 5 halts fetch; a redirect while halted is ignored.
    zero_en = 1'b1; zero_addr = 64'h6014;
    do_reset(64'h6000);
    begin
      int t = 0;
      while (!halted && t < 300) begin @(negedge clk); drive_ready(); #3; t++; end
    end
    check("t5_halted", 64'(halted), 64'd1);
    check("t5_delivered", 64'(accepts), 64'd5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      redirect = (i == 3); redirect_pc = 64'h1234;
      #1;
      check("t5_no_reqcyc", 64'(bus_reqcyc), 64'd0);
      check("t5_still_halted", 64'(halted), 64'd1);
    end
    redirect = 1'b0; zero_en = 1'b0;

    // Redirect while draining, random ready and random beat gaps.
    ready_mode = 2; gap_rand = 1'b1; gap_len = 2; ack_delay = int'($urandom_range(0, 3));
    do_reset(64'h7000);
    wait_accepts(3, 500, "t6_before");
    @(negedge clk);
    r = {$urandom, $urandom};
    redirect = 1'b1; redirect_pc = r; insn_ready = 1'b1; exp_pc = {r[63:2], 2'b0};
    @(negedge clk); redirect = 1'b0;
    wait_acks(2, 100, "t6_refetch");
    wait_accepts(3, 500, "t6_after");

    // Reset in the middle of a read, restart at a new entry.
    ready_mode = 0; gap_rand = 1'b0; gap_len = 1; ack_delay = 0;
    do_reset(64'h8000);
    wait_beat(4, 100, "t7_beat4");
    do_reset(64'h9000);
    wait_accepts(2, 200, "t7_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
